serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single one-bit full-adder cell and a carry flip-flop.
- Sits directly downstream of the one-bit full-adder stage: it consumes the cell's s/co each cycle, feeds co back as ci, and assembles the N-bit result LSB-first.
- Trades N cycles of latency for one adder cell.
- Operands are loaded with a start pulse; the result is presented with a one-cycle done strobe.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder_full_adder_cell.sv | 14 +
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder
package serial_adder_pkg;

    // Operand width used when the instantiating code does not override it
    localparam int DEFAULT_WIDTH = 8;

    // Bit counter sized to index every bit position 0..WIDTH-1
    localparam int DEFAULT_CNT_WIDTH = $clog2(DEFAULT_WIDTH);

    // Operation sequencing: waiting, shifting bits through the cell, presenting the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width for an arbitrary operand width (WIDTH >= 2 keeps this at least 1)
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle between a requester and the serial adder
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side drives operands and the start pulse, observes the result
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Adder side consumes operands and produces the result and status
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    // Sum and majority carry of the three input bits
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end
endmodule

// File: rtl/serial_adder.sv
// serial_adder: N-bit adder that pushes one bit per cycle through a single full-adder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             last_bit;

    // The cell always sees the current LSBs of both operands and the carry flop
    full_adder_cell u_fa (
        .a  (op_a_q[0]),
        .b  (op_b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath: load on start, shift each RUN cycle, publish on the last bit
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = fa_co;
                work_d  = {fa_s, work_q[WIDTH-1:1]};
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d   = {fa_s, work_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status decodes straight from the state so they follow an async reset at once
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic test_reset();
        #2;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", bus.busy, bus.done, bus.sum, bus.cout);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", bus.busy, bus.done, bus.sum, bus.cout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: busy=%b, required 0", bus.busy);
        end
    endtask

    // Starts one op from a negedge (cycle 0) and checks busy/done/sum/cout in cycles 1..W+2.
    // spur>0 pulses a second start in that cycle, which must be ignored.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] es, input logic ec, input int spur);
        logic [W-1:0] xs;
        logic         xc;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = ~a;
            bus.b     = ~b;
            bus.cin   = ~ci;
            xs = (c <= W) ? prev_sum : es;
            xc = (c <= W) ? prev_cout : ec;
            n_checks++;
            if (bus.busy !== (c <= W + 1)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b, required %b", nm, c, bus.busy, (c <= W + 1));
            end
            n_checks++;
            if (bus.done !== (c == W + 1)) begin
                n_fail++;
                $display("FAIL %s done cycle %0d: got %b, required %b", nm, c, bus.done, (c == W + 1));
            end
            n_checks++;
            if (bus.sum !== xs || bus.cout !== xc) begin
                n_fail++;
                $display("FAIL %s result cycle %0d: got cout=%b sum=%h, required cout=%b sum=%h", nm, c, bus.cout, bus.sum, xc, xs);
            end
            if (c == spur) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
                bus.cin   = 1'b0;
            end
        end
        prev_sum  = es;
        prev_cout = ec;
        bus.start = 1'b0;
    endtask

    task automatic test_basic();
        do_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0);
        do_op("ripple_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        do_op("max_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        do_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        do_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0);
    endtask

    task automatic test_start_while_busy();
        do_op("ignore_busy_start", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);
        do_op("ignore_done_start", 8'h80, 8'h81, 1'b0, 8'h01, 1'b1, W + 1);
    endtask

    task automatic test_reset_mid_op();
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", bus.busy, bus.done, bus.sum, bus.cout);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_held cycle %0d: done=%b busy=%b, required 0 0", c, bus.done, bus.busy);
            end
        end
        rst_n     = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        @(negedge clk);
        do_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic         eb, ed;
        logic [W-1:0] xs;
        logic         xc;
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'h5A;
        bus.cin   = 1'b0;
        for (int c = 1; c <= 2 * W + 4; c++) begin
            @(negedge clk);
            eb = (c >= 1 && c <= W + 1) || (c >= W + 3 && c <= 2 * W + 3);
            ed = (c == W + 1) || (c == 2 * W + 3);
            xs = (c <= W) ? prev_sum : (c <= 2 * W + 2) ? 8'h1D : 8'h81;
            xc = (c <= W) ? prev_cout : (c <= 2 * W + 2) ? 1'b1 : 1'b0;
            n_checks++;
            if (bus.busy !== eb) begin
                n_fail++;
                $display("FAIL b2b busy cycle %0d: got %b, required %b", c, bus.busy, eb);
            end
            n_checks++;
            if (bus.done !== ed) begin
                n_fail++;
                $display("FAIL b2b done cycle %0d: got %b, required %b", c, bus.done, ed);
            end
            n_checks++;
            if (bus.sum !== xs || bus.cout !== xc) begin
                n_fail++;
                $display("FAIL b2b result cycle %0d: got cout=%b sum=%h, required cout=%b sum=%h", c, bus.cout, bus.sum, xc, xs);
            end
            if (c == W + 1) begin
                bus.a   = 8'h7F;
                bus.b   = 8'h01;
                bus.cin = 1'b1;
            end
            if (c == 2 * W + 3) bus.start = 1'b0;
        end
        prev_sum  = 8'h81;
        prev_cout = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        test_reset();
        test_basic();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
